fu_arbiter: RTL and testbench

//   Shares one combinational function unit (FU) between two requesters (R0, R1).

---
 rtl/fu_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_fu_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_arbiter.sv
// fu_arbiter: shares one combinational function unit between two requesters.
// Round-robin grant, operand latching, registered result with {Z,C,N,V} flags,
// and a valid/ready response handshake to the granted requester.
// Optional build macro: LOCAL_FLAGS_EN (Z and N derived locally from FU_F).
module fu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5,
  parameter int unsigned FS_W   = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  // requester 0
  input  logic              R0_REQ_VALID,
  output logic              R0_REQ_READY,
  input  logic [DATA_W-1:0] R0_A,
  input  logic [DATA_W-1:0] R0_B,
  input  logic [SH_W-1:0]   R0_SH,
  input  logic [FS_W-1:0]   R0_FS,
  output logic              R0_RSP_VALID,
  input  logic              R0_RSP_READY,
  // requester 1
  input  logic              R1_REQ_VALID,
  output logic              R1_REQ_READY,
  input  logic [DATA_W-1:0] R1_A,
  input  logic [DATA_W-1:0] R1_B,
  input  logic [SH_W-1:0]   R1_SH,
  input  logic [FS_W-1:0]   R1_FS,
  output logic              R1_RSP_VALID,
  input  logic              R1_RSP_READY,
  // shared response
  output logic [DATA_W-1:0] RSP_F,
  output logic [3:0]        RSP_ZCNV,
  output logic              RSP_ERR,
  // function unit side
  output logic [DATA_W-1:0] FU_A,
  output logic [DATA_W-1:0] FU_B,
  output logic [SH_W-1:0]   FU_SH,
  output logic [FS_W-1:0]   FU_FS,
  input  logic [DATA_W-1:0] FU_F,
  input  logic              FU_Z,
  input  logic              FU_C,
  input  logic              FU_N,
  input  logic              FU_V,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // requester encoding for gnt/last: 0 = R0, 1 = R1
  localparam logic SEL_R0 = 1'b0;
  localparam logic SEL_R1 = 1'b1;

  state_t            state_q, state_d;
  logic              gnt_q, last_q;
  logic              grant_c, accept_c, legal_c, rsp_hs_c, gnt_next_c;

  logic [DATA_W-1:0] a_q, b_q;
  logic [SH_W-1:0]   sh_q;
  logic [FS_W-1:0]   fs_q;

  logic [DATA_W-1:0] sel_a_c, sel_b_c;
  logic [SH_W-1:0]   sel_sh_c;
  logic [FS_W-1:0]   sel_fs_c;

  logic [DATA_W-1:0] rsp_f_q;
  logic [3:0]        rsp_zcnv_q;
  logic              rsp_err_q;
  logic              r0_rsp_valid_q, r1_rsp_valid_q, busy_q;

  logic              flag_z_c, flag_n_c;

  // Function-select codes the FU implements; anything else is answered with an error.
  function automatic logic fs_legal(input logic [FS_W-1:0] fs);
    logic ok;
    ok = 1'b0;
    case (fs)
      FS_W'(5'b00000), FS_W'(5'b00010), FS_W'(5'b00101), FS_W'(5'b00111),
      FS_W'(5'b01000), FS_W'(5'b01010), FS_W'(5'b01100), FS_W'(5'b01110),
      FS_W'(5'b10000), FS_W'(5'b10001): ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Round-robin arbitration: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_c = SEL_R0;
    if (R0_REQ_VALID && R1_REQ_VALID) begin
      grant_c = ~last_q;
    end else if (R1_REQ_VALID) begin
      grant_c = SEL_R1;
    end
  end

  // Operand mux for the requester that would be granted this cycle.
  always_comb begin
    sel_a_c  = R0_A;
    sel_b_c  = R0_B;
    sel_sh_c = R0_SH;
    sel_fs_c = R0_FS;
    if (grant_c == SEL_R1) begin
      sel_a_c  = R1_A;
      sel_b_c  = R1_B;
      sel_sh_c = R1_SH;
      sel_fs_c = R1_FS;
    end
  end

  assign legal_c = fs_legal(sel_fs_c);

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    rsp_hs_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (R0_REQ_VALID || R1_REQ_VALID) begin
          accept_c = 1'b1;
          state_d  = legal_c ? EXEC : RESP;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_hs_c = (gnt_q == SEL_R1) ? R1_RSP_READY : R0_RSP_READY;
        if (rsp_hs_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_next_c = accept_c ? grant_c : gnt_q;

  // Accept strobes are combinational so a requester sees acceptance in the same cycle.
  assign R0_REQ_READY = accept_c && (grant_c == SEL_R0);
  assign R1_REQ_READY = accept_c && (grant_c == SEL_R1);

  // Flag sourcing: Z/N optionally recomputed from the result, C/V always from the FU.
`ifdef LOCAL_FLAGS_EN
  assign flag_z_c = (FU_F == '0);
  assign flag_n_c = FU_F[DATA_W-1];
`else
  assign flag_z_c = FU_Z;
  assign flag_n_c = FU_N;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant of the op in flight and last-served requester for round-robin.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      gnt_q  <= SEL_R0;
      last_q <= SEL_R1;
    end else begin
      if (accept_c) begin
        gnt_q <= grant_c;
      end
      if (rsp_hs_c) begin
        last_q <= gnt_q;
      end
    end
  end

  // Operand latch; illegal ops never reach the FU, so its inputs keep the previous op.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q  <= '0;
      b_q  <= '0;
      sh_q <= '0;
      fs_q <= '0;
    end else if (accept_c && legal_c) begin
      a_q  <= sel_a_c;
      b_q  <= sel_b_c;
      sh_q <= sel_sh_c;
      fs_q <= sel_fs_c;
    end
  end

  assign FU_A  = a_q;
  assign FU_B  = b_q;
  assign FU_SH = sh_q;
  assign FU_FS = fs_q;

  // Result capture: FU output at the end of EXEC, or a zeroed error response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_f_q    <= '0;
      rsp_zcnv_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept_c && !legal_c) begin
      rsp_f_q    <= '0;
      rsp_zcnv_q <= '0;
      rsp_err_q  <= 1'b1;
    end else if (state_q == EXEC) begin
      rsp_f_q    <= FU_F;
      rsp_zcnv_q <= {flag_z_c, FU_C, flag_n_c, FU_V};
      rsp_err_q  <= 1'b0;
    end
  end

  assign RSP_F    = rsp_f_q;
  assign RSP_ZCNV = rsp_zcnv_q;
  assign RSP_ERR  = rsp_err_q;

  // Registered response-valid and busy indications, decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      r0_rsp_valid_q <= (state_d == RESP) && (gnt_next_c == SEL_R0);
      r1_rsp_valid_q <= (state_d == RESP) && (gnt_next_c == SEL_R1);
      busy_q         <= (state_d != IDLE);
    end
  end

  assign R0_RSP_VALID = r0_rsp_valid_q;
  assign R1_RSP_VALID = r1_rsp_valid_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// tb_fu_arbiter: directed self-checking bench for fu_arbiter with a small FU model.
module tb_fu_arbiter;

  logic        CLK;
  logic        RESET;
  logic        R0_REQ_VALID, R0_REQ_READY, R0_RSP_VALID, R0_RSP_READY;
  logic [31:0] R0_A, R0_B;
  logic [4:0]  R0_SH, R0_FS;
  logic        R1_REQ_VALID, R1_REQ_READY, R1_RSP_VALID, R1_RSP_READY;
  logic [31:0] R1_A, R1_B;
  logic [4:0]  R1_SH, R1_FS;
  logic [31:0] RSP_F;
  logic [3:0]  RSP_ZCNV;
  logic        RSP_ERR;
  logic [31:0] FU_A, FU_B, FU_F;
  logic [4:0]  FU_SH, FU_FS;
  logic        FU_Z, FU_C, FU_N, FU_V;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  fu_arbiter #(.DATA_W(32), .SH_W(5), .FS_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .R0_REQ_VALID(R0_REQ_VALID), .R0_REQ_READY(R0_REQ_READY),
    .R0_A(R0_A), .R0_B(R0_B), .R0_SH(R0_SH), .R0_FS(R0_FS),
    .R0_RSP_VALID(R0_RSP_VALID), .R0_RSP_READY(R0_RSP_READY),
    .R1_REQ_VALID(R1_REQ_VALID), .R1_REQ_READY(R1_REQ_READY),
    .R1_A(R1_A), .R1_B(R1_B), .R1_SH(R1_SH), .R1_FS(R1_FS),
    .R1_RSP_VALID(R1_RSP_VALID), .R1_RSP_READY(R1_RSP_READY),
    .RSP_F(RSP_F), .RSP_ZCNV(RSP_ZCNV), .RSP_ERR(RSP_ERR),
    .FU_A(FU_A), .FU_B(FU_B), .FU_SH(FU_SH), .FU_FS(FU_FS),
    .FU_F(FU_F), .FU_Z(FU_Z), .FU_C(FU_C), .FU_N(FU_N), .FU_V(FU_V),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Minimal FU model: add, subtract, shift-left; flags driven directly by the bench.
  always_comb begin
    case (FU_FS)
      5'b00010: FU_F = FU_A + FU_B;
      5'b00101: FU_F = FU_A - FU_B;
      5'b10000: FU_F = FU_A << FU_SH;
      default:  FU_F = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    R0_REQ_VALID = 1'b0; R0_RSP_READY = 1'b0; R0_A = '0; R0_B = '0; R0_SH = '0; R0_FS = '0;
    R1_REQ_VALID = 1'b0; R1_RSP_READY = 1'b0; R1_A = '0; R1_B = '0; R1_SH = '0; R1_FS = '0;
    FU_Z = 1'b0; FU_C = 1'b0; FU_N = 1'b0; FU_V = 1'b0;

    // reset state
    do_reset();
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_r0_rsp_valid", 64'(R0_RSP_VALID), 64'd0);
    check("rst_r1_rsp_valid", 64'(R1_RSP_VALID), 64'd0);
    check("rst_rsp_f", 64'(RSP_F), 64'd0);
    check("rst_zcnv", 64'(RSP_ZCNV), 64'd0);
    check("rst_err", 64'(RSP_ERR), 64'd0);
    check("rst_fu_a", 64'(FU_A), 64'd0);
    check("rst_fu_fs", 64'(FU_FS), 64'd0);

    // single R0 add: 5 + 7
    FU_Z = 1'b0; FU_C = 1'b1; FU_N = 1'b0; FU_V = 1'b1;
    R0_RSP_READY = 1'b1; R1_RSP_READY = 1'b1;
    R0_A = 32'd5; R0_B = 32'd7; R0_FS = 5'b00010; R0_REQ_VALID = 1'b1;
    #1;
    check("add_r0_ready", 64'(R0_REQ_READY), 64'd1);
    check("add_r1_ready", 64'(R1_REQ_READY), 64'd0);
    cyc();
    R0_REQ_VALID = 1'b0;
    check("add_exec_busy", 64'(BUSY), 64'd1);
    check("add_exec_novalid", 64'(R0_RSP_VALID), 64'd0);
    check("add_fu_a", 64'(FU_A), 64'd5);
    check("add_fu_b", 64'(FU_B), 64'd7);
    cyc();
    check("add_rsp_valid", 64'(R0_RSP_VALID), 64'd1);
    check("add_rsp_f", 64'(RSP_F), 64'd12);
    check("add_rsp_err", 64'(RSP_ERR), 64'd0);
    check("add_zcnv", 64'(RSP_ZCNV), 64'b0101);
    cyc();
    check("add_done_busy", 64'(BUSY), 64'd0);
    check("add_done_valid", 64'(R0_RSP_VALID), 64'd0);

    // tie from reset: R0 first, then R1 by round-robin while R0 still requests
    do_reset();
    R0_A = 32'd1; R0_B = 32'd1; R0_FS = 5'b00010; R0_REQ_VALID = 1'b1;
    R1_A = 32'd9; R1_B = 32'd3; R1_FS = 5'b00101; R1_REQ_VALID = 1'b1;
    #1;
    check("tie_r0_ready", 64'(R0_REQ_READY), 64'd1);
    check("tie_r1_ready", 64'(R1_REQ_READY), 64'd0);
    cyc();
    cyc();
    check("tie_r0_rsp_valid", 64'(R0_RSP_VALID), 64'd1);
    check("tie_r1_rsp_quiet", 64'(R1_RSP_VALID), 64'd0);
    check("tie_r0_f", 64'(RSP_F), 64'd2);
    cyc();
    check("rr_r1_ready", 64'(R1_REQ_READY), 64'd1);
    check("rr_r0_ready", 64'(R0_REQ_READY), 64'd0);
    cyc();
    R0_REQ_VALID = 1'b0; R1_REQ_VALID = 1'b0;
    cyc();
    check("rr_r1_rsp_valid", 64'(R1_RSP_VALID), 64'd1);
    check("rr_r0_rsp_quiet", 64'(R0_RSP_VALID), 64'd0);
    check("rr_r1_f", 64'(RSP_F), 64'd6);
    cyc();

    // R1 shift with back-pressure; operands change after accept
    R1_RSP_READY = 1'b0;
    R1_A = 32'd1; R1_B = 32'd0; R1_SH = 5'd4; R1_FS = 5'b10000; R1_REQ_VALID = 1'b1;
    #1;
    check("shl_r1_ready", 64'(R1_REQ_READY), 64'd1);
    cyc();
    R1_REQ_VALID = 1'b0; R1_A = 32'd7; R1_SH = 5'd1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("shl_hold_valid", 64'(R1_RSP_VALID), 64'd1);
      check("shl_hold_f", 64'(RSP_F), 64'd16);
      check("shl_hold_busy", 64'(BUSY), 64'd1);
      cyc();
    end
    R1_RSP_READY = 1'b1;
    cyc();
    check("shl_done_busy", 64'(BUSY), 64'd0);
    check("shl_done_valid", 64'(R1_RSP_VALID), 64'd0);

    // illegal function select: error response one cycle after accept
    R0_A = 32'd3; R0_B = 32'd4; R0_FS = 5'b00011; R0_REQ_VALID = 1'b1;
    #1;
    check("ill_r0_ready", 64'(R0_REQ_READY), 64'd1);
    cyc();
    R0_REQ_VALID = 1'b0;
    check("ill_rsp_valid", 64'(R0_RSP_VALID), 64'd1);
    check("ill_err", 64'(RSP_ERR), 64'd1);
    check("ill_f", 64'(RSP_F), 64'd0);
    check("ill_zcnv", 64'(RSP_ZCNV), 64'd0);
    check("ill_fu_fs_kept", 64'(FU_FS), 64'b10000);
    cyc();
    check("ill_done_busy", 64'(BUSY), 64'd0);

    // reset during EXEC discards the op and restores R0 tie priority
    R0_A = 32'd2; R0_B = 32'd2; R0_FS = 5'b00010; R0_REQ_VALID = 1'b1;
    #1;
    cyc();
    R0_REQ_VALID = 1'b0;
    check("mid_exec_busy", 64'(BUSY), 64'd1);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_rsp0", 64'(R0_RSP_VALID), 64'd0);
      check("mid_rst_no_rsp1", 64'(R1_RSP_VALID), 64'd0);
      cyc();
    end

    // tie after reset goes to R0; subtract to zero exercises flag sourcing
    FU_Z = 1'b0; FU_C = 1'b0; FU_N = 1'b1; FU_V = 1'b0;
    R0_A = 32'd3; R0_B = 32'd3; R0_SH = 5'd0; R0_FS = 5'b00101; R0_REQ_VALID = 1'b1;
    R1_A = 32'd8; R1_B = 32'd1; R1_FS = 5'b00010; R1_REQ_VALID = 1'b1;
    #1;
    check("post_rst_tie_r0", 64'(R0_REQ_READY), 64'd1);
    check("post_rst_tie_r1", 64'(R1_REQ_READY), 64'd0);
    cyc();
    R0_REQ_VALID = 1'b0; R1_REQ_VALID = 1'b0;
    cyc();
    check("flag_rsp_valid", 64'(R0_RSP_VALID), 64'd1);
    check("flag_f", 64'(RSP_F), 64'd0);
`ifdef LOCAL_FLAGS_EN
    check("flag_zcnv", 64'(RSP_ZCNV), 64'b1000);
`else
    check("flag_zcnv", 64'(RSP_ZCNV), 64'b0010);
`endif
    cyc();
    check("flag_done_busy", 64'(BUSY), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
